// File: rtl/inter_pred_seq_if.sv
// inter_pred_seq_if: start/reference/handshake bundle between address logic, sequencer and reconstruction
interface inter_pred_seq_if #(
  parameter int MB_X_BITS = 7,
  parameter int MB_Y_BITS = 7,
  parameter int CNT_W     = 8
);
  logic                   start;
  logic [4:0]             blk4x4_counter;
  logic [MB_X_BITS+5:0]   ref_x;
  logic [MB_Y_BITS+5:0]   ref_y;
  logic                   ref_mem_ready;
  logic [CNT_W-1:0]       ref_nword_left;
  logic                   out_ready;
  logic                   out_valid;
  modport master (output start, blk4x4_counter, ref_x, ref_y, ref_mem_ready, ref_nword_left, out_ready,
                  input out_valid);
  modport slave (input start, blk4x4_counter, ref_x, ref_y, ref_mem_ready, ref_nword_left, out_ready,
                 output out_valid);
endinterface

// File: rtl/inter_pred_seq.sv
// inter_pred_seq: per-4x4 inter prediction load/calc sequencer; INTER_PRED_SEQ_WATCHDOG_EN adds a load-stall watchdog
module inter_pred_seq #(
  parameter int MB_X_BITS      = 7,
  parameter int MB_Y_BITS      = 7,
  parameter int CNT_W          = 8,
  parameter int LOAD_INT       = 5,
  parameter int LOAD_XFRAC     = 13,
  parameter int LOAD_YFRAC     = 10,
  parameter int LOAD_XYFRAC    = 28,
  parameter int LOAD_C_INT     = 5,
  parameter int LOAD_C_FRAC    = 11,
  parameter int CALC_LAT       = 3,
  parameter int NUM_CHROMA_BLK = 4,
  parameter int WDOG_CYCLES    = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               abort,
  inter_pred_seq_if.slave    bus,
  output logic               busy,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   counter,
  output logic               chroma_cb_sel,
  output logic               chroma_cr_sel,
  output logic [1:0]         frac_mode,
  output logic               err
);
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, CALC = 3'd2, DONE = 3'd3} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, pre;
  logic [1:0] fm_q, fm_d;
  logic ov_q, ov_d, cb_q, cb_d, cr_q, cr_d;
  logic luma, cb, xf, yf, load_end, hs, accept, unused_ref;
  assign unused_ref = ^{bus.ref_x[MB_X_BITS+5:3], bus.ref_y[MB_Y_BITS+5:3]};
  assign luma = bus.blk4x4_counter < 5'd16;
  assign cb = !luma && int'(bus.blk4x4_counter) < 16 + NUM_CHROMA_BLK;
  assign xf = luma ? |bus.ref_x[1:0] : |bus.ref_x[2:0];
  assign yf = luma ? |bus.ref_y[1:0] : |bus.ref_y[2:0];
  assign pre = luma ? (xf && yf ? CNT_W'(LOAD_XYFRAC) : xf ? CNT_W'(LOAD_XFRAC) :
                       yf ? CNT_W'(LOAD_YFRAC) : CNT_W'(LOAD_INT))
                    : (xf || yf ? CNT_W'(LOAD_C_FRAC) : CNT_W'(LOAD_C_INT));
  assign load_end = bus.ref_nword_left == '0;
  assign hs = ov_q && bus.out_ready;
  assign accept = bus.start && (state_q == IDLE || (state_q == DONE && hs));
`ifdef INTER_PRED_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic err_q, err_d;
  assign err = err_q;
`else
  localparam int unused_wdog = WDOG_CYCLES;
  assign err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ov_d = ov_q;
    cb_d = cb_q;
    cr_d = cr_q;
    fm_d = fm_q;
    if (accept) begin
      state_d = LOAD;
      cnt_d = pre;
      ov_d = 1'b0;
      cb_d = cb;
      cr_d = !luma && !cb;
      fm_d = {yf, xf};
    end else begin
      case (state_q)
        LOAD: begin
          if (load_end) begin
            state_d = CALC;
            cnt_d = fm_q == 2'b00 ? '0 : CNT_W'(CALC_LAT);
          end else if (bus.ref_mem_ready && cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
        CALC: begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else begin
            state_d = DONE;
            ov_d = 1'b1;
          end
        end
        DONE: begin
          if (hs) begin
            state_d = IDLE;
            ov_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
`ifdef INTER_PRED_SEQ_WATCHDOG_EN
    err_d = err_q;
    wd_d = (state_q == LOAD && !bus.ref_mem_ready && !load_end) ? wd_q + 1'b1 : '0;
    if (wd_d == WD_W'(WDOG_CYCLES)) begin
      err_d = 1'b1;
      wd_d = '0;
      state_d = IDLE;
      cnt_d = '0;
    end
`endif
    if (abort) begin
      state_d = IDLE;
      cnt_d = '0;
      ov_d = 1'b0;
`ifdef INTER_PRED_SEQ_WATCHDOG_EN
      wd_d = '0;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ov_q <= 1'b0;
      cb_q <= 1'b0;
      cr_q <= 1'b0;
      fm_q <= 2'b00;
`ifdef INTER_PRED_SEQ_WATCHDOG_EN
      wd_q <= '0;
      err_q <= 1'b0;
`endif
    end else if (ena) begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ov_q <= ov_d;
      cb_q <= cb_d;
      cr_q <= cr_d;
      fm_q <= fm_d;
`ifdef INTER_PRED_SEQ_WATCHDOG_EN
      wd_q <= wd_d;
      err_q <= err_d;
`endif
    end
  end
  assign bus.out_valid = ov_q;
  assign busy = state_q != IDLE;
  assign state = state_q;
  assign counter = cnt_q;
  assign chroma_cb_sel = cb_q;
  assign chroma_cr_sel = cr_q;
  assign frac_mode = fm_q;
endmodule

// File: tb/tb_inter_pred_seq.sv
// tb_inter_pred_seq: directed bench with a completion scoreboard for inter_pred_seq
module tb_inter_pred_seq;
  logic clk = 1'b0, rst, ena, abort, abort8;
  logic busy, cb_sel, cr_sel, err, busy8, cb8, cr8, err8;
  logic [2:0] state, state8;
  logic [7:0] counter, counter8;
  logic [1:0] frac_mode, fm8;
  int cyc = 0, ncmp = 0, nfail = 0;
  typedef struct {int id; int due; logic cb; logic cr; logic [1:0] fm;} exp_t;
  exp_t sb[$];
  inter_pred_seq_if bus();
  inter_pred_seq_if bus8();
  always #5 clk = ~clk;
  inter_pred_seq #(.WDOG_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .ena(ena), .abort(abort), .bus(bus), .busy(busy), .state(state),
    .counter(counter), .chroma_cb_sel(cb_sel), .chroma_cr_sel(cr_sel), .frac_mode(frac_mode), .err(err));
  inter_pred_seq #(.NUM_CHROMA_BLK(8), .WDOG_CYCLES(16)) dut8 (
    .clk(clk), .rst(rst), .ena(ena), .abort(abort8), .bus(bus8), .busy(busy8), .state(state8),
    .counter(counter8), .chroma_cb_sel(cb8), .chroma_cr_sel(cr8), .frac_mode(fm8), .err(err8));
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic do_start(input int b, input int x, input int y);
    bus.start = 1'b1;
    bus.blk4x4_counter = b[4:0];
    bus.ref_x = x[12:0];
    bus.ref_y = y[12:0];
    tick();
    bus.start = 1'b0;
  endtask
  task automatic push(input int id, input int due, input logic c_b, input logic c_r, input logic [1:0] fm);
    sb.push_back('{id, due, c_b, c_r, fm});
  endtask
  task automatic wait_done();
    exp_t e;
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(bus.out_valid), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      $display("block %0d completed at cycle %0d", e.id, cyc);
      chk("done_cycle", cyc, e.due);
      chk("done_cb", 32'(cb_sel), 32'(e.cb));
      chk("done_cr", 32'(cr_sel), 32'(e.cr));
      chk("done_fm", 32'(frac_mode), 32'(e.fm));
    end else chk("sb_underflow", 0, 1);
  endtask
  initial begin
    int p;
    rst = 1'b1; ena = 1'b1; abort = 1'b0; abort8 = 1'b0;
    bus.start = 1'b0; bus.blk4x4_counter = '0; bus.ref_x = '0; bus.ref_y = '0;
    bus.ref_mem_ready = 1'b0; bus.ref_nword_left = 8'd3; bus.out_ready = 1'b0;
    bus8.start = 1'b0; bus8.blk4x4_counter = '0; bus8.ref_x = '0; bus8.ref_y = '0;
    bus8.ref_mem_ready = 1'b0; bus8.ref_nword_left = 8'd3; bus8.out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_counter", 32'(counter), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_cb", 32'(cb_sel), 0);
    chk("rst_cr", 32'(cr_sel), 0);
    chk("rst_fm", 32'(frac_mode), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    // luma, integer position
    do_start(3, 8, 4);
    chk("lint_state", 32'(state), 1);
    chk("lint_pre", 32'(counter), 5);
    chk("lint_fm", 32'(frac_mode), 0);
    tick(); tick();
    chk("lint_wait", 32'(state), 1);
    bus.ref_nword_left = 8'd0;
    push(1, cyc + 2, 1'b0, 1'b0, 2'b00);
    tick();
    chk("lint_calc", 32'(state), 2);
    chk("lint_calc_cnt", 32'(counter), 0);
    wait_done();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("lint_clr", 32'(bus.out_valid), 0);
    chk("lint_idle", 32'(state), 0);
    // luma, both fractional
    bus.ref_nword_left = 8'd10;
    do_start(0, 1, 2);
    chk("lxy_pre", 32'(counter), 28);
    chk("lxy_fm", 32'(frac_mode), 3);
    bus.ref_mem_ready = 1'b1;
    repeat (5) tick();
    bus.ref_mem_ready = 1'b0;
    chk("lxy_dec", 32'(counter), 23);
    bus.ref_nword_left = 8'd0;
    push(2, cyc + 5, 1'b0, 1'b0, 2'b11);
    tick();
    chk("lxy_calc", 32'(counter), 3);
    wait_done();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    // y-only fractional, then abort mid-LOAD
    bus.ref_nword_left = 8'd3;
    do_start(0, 0, 1);
    chk("ly_pre", 32'(counter), 10);
    chk("ly_fm", 32'(frac_mode), 2);
    bus.ref_mem_ready = 1'b1;
    repeat (3) tick();
    bus.ref_mem_ready = 1'b0;
    chk("ly_dec", 32'(counter), 7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_load_state", 32'(state), 0);
    chk("abort_load_cnt", 32'(counter), 0);
    // x-only fractional
    do_start(0, 1, 0);
    chk("lx_pre", 32'(counter), 13);
    chk("lx_fm", 32'(frac_mode), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    // abort wins over start in IDLE
    abort = 1'b1;
    do_start(4, 0, 0);
    abort = 1'b0;
    chk("abort_start_state", 32'(state), 0);
    chk("abort_start_cnt", 32'(counter), 0);
    // chroma Cb with one-cycle LOAD
    bus.ref_nword_left = 8'd0;
    do_start(17, 8, 16);
    chk("cb_state", 32'(state), 1);
    chk("cb_sel", 32'(cb_sel), 1);
    chk("cb_cr", 32'(cr_sel), 0);
    chk("cb_pre", 32'(counter), 5);
    push(3, cyc + 2, 1'b1, 1'b0, 2'b00);
    wait_done();
    // DONE holds, start without out_ready is ignored
    do_start(21, 3, 0);
    chk("done_ign_start", 32'(state), 3);
    repeat (3) tick();
    chk("done_hold", 32'(bus.out_valid), 1);
    // handshake with start: back-to-back Cr block
    bus.ref_nword_left = 8'd3;
    bus.out_ready = 1'b1;
    do_start(21, 3, 0);
    bus.out_ready = 1'b0;
    chk("b2b_state", 32'(state), 1);
    chk("b2b_valid", 32'(bus.out_valid), 0);
    chk("cr_sel", 32'(cr_sel), 1);
    chk("cr_cb", 32'(cb_sel), 0);
    chk("cr_pre", 32'(counter), 11);
    bus.ref_nword_left = 8'd0;
    push(4, cyc + 5, 1'b0, 1'b1, 2'b01);
    wait_done();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("cr_idle", 32'(state), 0);
    // ena low mid-CALC
    do_start(5, 1, 1);
    p = cyc;
    tick();
    chk("ena_calc", 32'(counter), 3);
    ena = 1'b0;
    repeat (3) tick();
    chk("ena_frozen", 32'(counter), 3);
    chk("ena_frozen_state", 32'(state), 2);
    ena = 1'b1;
    push(5, p + 8, 1'b0, 1'b0, 2'b11);
    wait_done();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    // 4:2:2 chroma decode
    bus8.start = 1'b1;
    bus8.blk4x4_counter = 5'd22;
    tick();
    bus8.start = 1'b0;
    chk("c8_cb", 32'(cb8), 1);
    chk("c8_cr", 32'(cr8), 0);
    abort8 = 1'b1;
    tick();
    abort8 = 1'b0;
    bus8.start = 1'b1;
    bus8.blk4x4_counter = 5'd24;
    tick();
    bus8.start = 1'b0;
    chk("c8_cr24", 32'(cr8), 1);
    chk("c8_cb24", 32'(cb8), 0);
    // stalled load
    bus.ref_nword_left = 8'd3;
    do_start(0, 0, 0);
    repeat (15) tick();
    chk("wd_pre_state", 32'(state), 1);
    chk("wd_pre_err", 32'(err), 0);
    tick();
`ifdef INTER_PRED_SEQ_WATCHDOG_EN
    chk("wd_err", 32'(err), 1);
    chk("wd_state", 32'(state), 0);
    chk("wd_cnt", 32'(counter), 0);
    tick();
    chk("wd_sticky", 32'(err), 1);
`else
    chk("nowd_err", 32'(err), 0);
    chk("nowd_state", 32'(state), 1);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst2_err", 32'(err), 0);
    chk("rst2_state", 32'(state), 0);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
